pixel_writer: RTL
=================

Name: pixel_writer

Overview:
- Producer-side counterpart of the TFT pixel path.
- Accepts RGB pixels over a rdy/stb handshake, packs each into a 24-bit word and streams it into a ping-pong FIFO write port.
- Sits between a pixel generator (pattern source, DMA unpacker) and the ping-pong FIFO that feeds the TFT pixel reader.
- Commits partial buffers at frame end so no pixels are stranded.

Parameters:
- FIFO_SIZE_W, 24, width of i_write_size and of the internal write counter.
- TIMEOUT_CYCLES, 1024, idle cycles before an auto-flush; used only with PIXEL_WRITER_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_write_rdy  in  2  ping-pong FIFO buffer-available flags, one per buffer
- o_write_act  out  2  one-hot buffer ownership; at most one bit high
- i_write_size  in  FIFO_SIZE_W  capacity of the owned buffer in words
- o_write_data  out  24  packed pixel {red, green, blue}
- o_write_stb  out  1  one-cycle write strobe into the owned buffer
- i_red  in  8  pixel red
- i_green  in  8  pixel green
- i_blue  in  8  pixel blue
- i_pixel_stb  in  1  producer strobe; a pixel is accepted when i_pixel_stb and o_pixel_rdy are both high
- o_pixel_rdy  out  1  block can accept a pixel this cycle
- i_frame_end  in  1  one-cycle pulse; commit the current buffer even if partial
- o_buf_count  out  FIFO_SIZE_W  words written into the currently owned buffer

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset values: o_write_act=0, o_write_stb=0, o_write_data=0, o_pixel_rdy=0, o_buf_count=0, state=IDLE. Reset mid-buffer drops ownership on the next edge; no strobe is issued.
- All outputs are registered.
- State IDLE:
  - If i_write_rdy!=0, set o_write_act to bit 0 when i_write_rdy[0] is high, else bit 1.
  - Set count=0 and go to FILL.
  - o_pixel_rdy stays 0 in IDLE.
- State FILL:
  - o_pixel_rdy=1 while count<i_write_size.
  - On accept at edge N: o_write_data<={i_red,i_green,i_blue}, o_write_stb=1 during cycle N+1, count+1.
  - Latency from accept to strobe: 1 cycle. Back-to-back accepts give back-to-back strobes (one word per clock).
  - When count+1==i_write_size on an accept, o_pixel_rdy<=0 on the same edge and go to RELEASE.
  - i_frame_end with count>0 (including a simultaneous accept, which is counted) goes to RELEASE with o_pixel_rdy<=0.
  - i_frame_end with count==0 is ignored, so empty buffers are never committed.
- State RELEASE:
  - o_write_act<=0 at the edge after the final strobe, so the strobe is always seen while act is high.
  - Then go to IDLE.
  - A new buffer can be acquired no earlier than the following cycle.
- Boundaries:
  - i_write_size==0 on acquire: go directly to RELEASE with no strobes.
  - i_pixel_stb while o_pixel_rdy==0 is ignored; the pixel is lost, and preventing this is the producer's responsibility.
  - count never exceeds i_write_size and does not wrap.
  - o_buf_count mirrors count and clears to 0 on acquire.

Optional Feature:
- Macro PIXEL_WRITER_TIMEOUT_EN.
- Defined:
  - An idle counter in FILL increments on every cycle without an accept and clears on accept.
  - When it reaches TIMEOUT_CYCLES with count>0, the block behaves as if i_frame_end were pulsed (goes to RELEASE).
  - The counter clears on reset and on entering FILL.
- Undefined: no counter logic; a partial buffer is committed only by i_frame_end or when full.

Decomposition:
- Package pixel_writer_pkg holds:
  - state encoding: IDLE=2'd0, FILL=2'd1, RELEASE=2'd2
  - PIXEL_W=24
  - channel slice constants: RED=23:16, GREEN=15:8, BLUE=7:0 (shared with the pixel reader)
- No sub-module; the FSM, counter and optional timeout counter stay inline.

Test Plan:
- Reset, then i_write_rdy=2'b11 -> o_write_act=2'b01 one cycle later; o_pixel_rdy=1 the cycle after.
- i_write_size=4, stream pixels 0x112233..0x445566 back-to-back -> four consecutive o_write_stb with matching data, o_pixel_rdy low after the 4th accept, o_write_act cleared one cycle after the last strobe.
- i_write_size=8, accept 3 pixels, pulse i_frame_end -> 3 strobes, o_buf_count=3, act released; i_frame_end with 0 pixels -> no release.
- Second buffer: i_write_rdy=2'b10 after the first release -> o_write_act=2'b10; rst mid-fill -> act=0, stb=0, rdy=0 next edge.
- With PIXEL_WRITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, accept 2 pixels then idle -> act released after 16 idle cycles; without the macro, act held indefinitely.

Source files
------------

// File: rtl/pixel_writer_pkg.sv
// rtl/pixel_writer_pkg.sv - shared state encoding, pixel width and channel slices for the pixel path
package pixel_writer_pkg;

  localparam int PIXEL_W = 24;

  // Channel slice positions, shared with the pixel reader
  localparam int RED_HI   = 23;
  localparam int RED_LO   = 16;
  localparam int GREEN_HI = 15;
  localparam int GREEN_LO = 8;
  localparam int BLUE_HI  = 7;
  localparam int BLUE_LO  = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  function automatic logic [PIXEL_W-1:0] pack_pixel(
    input logic [7:0] red,
    input logic [7:0] green,
    input logic [7:0] blue
  );
    logic [PIXEL_W-1:0] word;
    word                    = '0;
    word[RED_HI:RED_LO]     = red;
    word[GREEN_HI:GREEN_LO] = green;
    word[BLUE_HI:BLUE_LO]   = blue;
    return word;
  endfunction

endpackage

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - packs RGB pixels into 24-bit words and fills ping-pong FIFO buffers
// Optional idle auto-flush enabled by defining PIXEL_WRITER_TIMEOUT_EN.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int FIFO_SIZE_W = 24
`ifdef PIXEL_WRITER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             i_write_rdy,
  output logic [1:0]             o_write_act,
  input  logic [FIFO_SIZE_W-1:0] i_write_size,
  output logic [PIXEL_W-1:0]     o_write_data,
  output logic                   o_write_stb,
  input  logic [7:0]             i_red,
  input  logic [7:0]             i_green,
  input  logic [7:0]             i_blue,
  input  logic                   i_pixel_stb,
  output logic                   o_pixel_rdy,
  input  logic                   i_frame_end,
  output logic [FIFO_SIZE_W-1:0] o_buf_count
);

  state_t                 state;
  logic                   accept;
  logic                   end_req;
  logic [FIFO_SIZE_W-1:0] count_inc;
  logic [FIFO_SIZE_W-1:0] count_next;

  // o_pixel_rdy is only ever high in FILL, so accept implies FILL
  assign accept     = i_pixel_stb && o_pixel_rdy;
  assign count_inc  = o_buf_count + FIFO_SIZE_W'(1);
  assign count_next = accept ? count_inc : o_buf_count;

`ifdef PIXEL_WRITER_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout_hit;

  // Fires on the TIMEOUT_CYCLES-th consecutive idle cycle of a non-empty buffer
  assign timeout_hit = !accept && (o_buf_count != '0) &&
                       (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign end_req     = i_frame_end || timeout_hit;

  always_ff @(posedge clk) begin
    if (rst || state != FILL || accept) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES - 1)) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  assign end_req = i_frame_end;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      o_write_act  <= 2'b00;
      o_write_stb  <= 1'b0;
      o_write_data <= '0;
      o_pixel_rdy  <= 1'b0;
      o_buf_count  <= '0;
    end else begin
      o_write_stb <= 1'b0;
      case (state)
        IDLE: begin
          o_pixel_rdy <= 1'b0;
          if (i_write_rdy != 2'b00) begin
            o_write_act <= i_write_rdy[0] ? 2'b01 : 2'b10;
            o_buf_count <= '0;
            state       <= (i_write_size == '0) ? RELEASE : FILL;
          end
        end

        FILL: begin
          if (accept) begin
            o_write_stb  <= 1'b1;
            o_write_data <= pack_pixel(i_red, i_green, i_blue);
            o_buf_count  <= count_inc;
          end
          // Empty buffers are never committed by a frame end
          if ((count_next >= i_write_size) || (end_req && count_next != '0)) begin
            o_pixel_rdy <= 1'b0;
            state       <= RELEASE;
          end else begin
            o_pixel_rdy <= 1'b1;
          end
        end

        RELEASE: begin
          // The final strobe is in flight this cycle, so act drops only now
          o_pixel_rdy <= 1'b0;
          o_write_act <= 2'b00;
          state       <= IDLE;
        end

        default: begin
          o_pixel_rdy <= 1'b0;
          o_write_act <= 2'b00;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
